// File: rtl/pong_pkg.sv
// Shared definitions for the pong display drawers (ball and paddles).
// Holds the screen geometry, the RGB565 colour constants, the draw-state
// enumeration used by every sprite drawer, and a helper that tells whether
// a widened (un-wrapped) coordinate lands on the visible screen.
package pong_pkg;

    localparam int unsigned SCREEN_W = 240;
    localparam int unsigned SCREEN_H = 320;

    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2
    } draw_state_e;

    // Coordinates are one bit wider than the screen range so that an
    // origin near the edge plus an offset never wraps back on-screen.
    function automatic logic in_screen(
        input logic [8:0] x,
        input logic [9:0] y,
        input int unsigned w,
        input int unsigned h
    );
        return (x < 9'(w)) && (y < 10'(h));
    endfunction

endpackage

// File: rtl/ball_sprite_drawer_if.sv
// Pixel write port between a sprite drawer and the LCD/framebuffer writer.
// A pixel transfers when pixel_valid && pixel_ready on a rising clock edge.
//   pixel_valid  : drawer -> writer, request to write one pixel
//   pixel_ready  : writer -> drawer, writer accepts this cycle
//   pixel_x      : column 0..239
//   pixel_y      : row 0..319
//   pixel_colour : RGB565 data
interface ball_sprite_drawer_if;

    logic        pixel_valid;
    logic        pixel_ready;
    logic [7:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [15:0] pixel_colour;

    modport master (
        output pixel_valid,
        output pixel_x,
        output pixel_y,
        output pixel_colour,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid,
        input  pixel_x,
        input  pixel_y,
        input  pixel_colour,
        output pixel_ready
    );

endinterface

// File: rtl/ball_sprite_drawer_rect_scanner.sv
// Row-major scanner over a SIZE x SIZE rectangle with screen clipping.
// Keeps the (col,row) counter pair of the pixel currently being presented
// and looks one step ahead: given the control for this cycle and the origin
// that will apply next cycle, it produces the screen coordinate of the next
// pixel and whether that pixel is on screen, so the caller can register it.
//   clock, reset     : clock, synchronous active-high reset
//   clear            : next position is (0,0)
//   advance          : step to the next position (col fastest)
//   origin_x/y       : rectangle origin that applies to the next position
//   last             : current position is (SIZE-1, SIZE-1)
//   next_x/next_y    : next screen coordinate (valid when next_in_bounds)
//   next_in_bounds   : next coordinate lies inside the screen
module rect_scanner
    import pong_pkg::*;
#(
    parameter int unsigned SIZE     = 10,
    parameter int unsigned SCREEN_W = pong_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = pong_pkg::SCREEN_H
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [7:0] origin_x,
    input  logic [8:0] origin_y,
    output logic       last,
    output logic [7:0] next_x,
    output logic [8:0] next_y,
    output logic       next_in_bounds
);

    localparam logic [3:0] LAST_IDX = 4'(SIZE - 1);

    logic [3:0] col_r;
    logic [3:0] row_r;
    logic [3:0] col_nxt_s;
    logic [3:0] row_nxt_s;
    logic [8:0] sum_x_s;
    logic [9:0] sum_y_s;

    // Next counter position: clear wins, otherwise step row-major.
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (clear) begin
            col_nxt_s = 4'd0;
            row_nxt_s = 4'd0;
        end else if (advance) begin
            if (col_r == LAST_IDX) begin
                col_nxt_s = 4'd0;
                if (row_r == LAST_IDX) begin
                    row_nxt_s = 4'd0;
                end else begin
                    row_nxt_s = row_r + 4'd1;
                end
            end else begin
                col_nxt_s = col_r + 4'd1;
                row_nxt_s = row_r;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // Counter pair register.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_r <= 4'd0;
            row_r <= 4'd0;
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // Widened sums so an origin near the edge cannot wrap back on-screen.
    assign sum_x_s        = {1'b0, origin_x} + {5'd0, col_nxt_s};
    assign sum_y_s        = {1'b0, origin_y} + {6'd0, row_nxt_s};
    assign next_x         = sum_x_s[7:0];
    assign next_y         = sum_y_s[8:0];
    assign next_in_bounds = in_screen(sum_x_s, sum_y_s, SCREEN_W, SCREEN_H);
    assign last           = (col_r == LAST_IDX) && (row_r == LAST_IDX);

endmodule

// File: rtl/ball_sprite_drawer.sv
// Ball sprite drawer. On each frame tick it samples the ball position and
// rasterises the ball as a SIZE x SIZE square onto the pixel write port,
// first erasing the previously drawn square with the background colour.
// An unchanged position skips the update entirely. Ticks that arrive while
// an update runs collapse into one follow-on update.
//   clock, reset : system clock, synchronous active-high reset
//   frame_tick   : one-cycle redraw request
//   ball_x/y     : top-left corner of the ball
//   pix          : pixel write port (valid/ready, x, y, colour)
//   busy         : high whenever an update is in progress
//   done         : one-cycle pulse after an update finishes (or is skipped)
module ball_sprite_drawer
    import pong_pkg::*;
#(
    parameter int unsigned SIZE      = 10,
    parameter int unsigned SCREEN_W  = pong_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H  = pong_pkg::SCREEN_H,
    parameter logic [15:0] FG_COLOUR = RGB565_WHITE,
    parameter logic [15:0] BG_COLOUR = RGB565_BLACK
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic [7:0]                  ball_x,
    input  logic [8:0]                  ball_y,
    ball_sprite_drawer_if.master        pix,
    output logic                        busy,
    output logic                        done
);

    draw_state_e state_r;
    draw_state_e state_nxt_s;

    logic [7:0]  old_x_r;
    logic [8:0]  old_y_r;
    logic [7:0]  new_x_r;
    logic [8:0]  new_y_r;
    logic        drawn_valid_r;
    logic        pending_r;
    logic        pending_nxt_s;

    logic        pixel_valid_r;
    logic [7:0]  pixel_x_r;
    logic [8:0]  pixel_y_r;
    logic [15:0] pixel_colour_r;
    logic        busy_r;
    logic        done_r;

    logic        start_s;
    logic        slot_done_s;
    logic        clear_s;
    logic        advance_s;
    logic        latch_s;
    logic        commit_s;
    logic        done_nxt_s;
    logic [7:0]  origin_x_s;
    logic [8:0]  origin_y_s;

    logic        last_s;
    logic [7:0]  next_x_s;
    logic [8:0]  next_y_s;
    logic        next_in_bounds_s;

    rect_scanner #(
        .SIZE     (SIZE),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scanner (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear_s),
        .advance        (advance_s),
        .origin_x       (origin_x_s),
        .origin_y       (origin_y_s),
        .last           (last_s),
        .next_x         (next_x_s),
        .next_y         (next_y_s),
        .next_in_bounds (next_in_bounds_s)
    );

    // A pending tick restarts an update exactly as a fresh tick would.
    assign start_s = frame_tick || pending_r;

    // The current scan slot is finished when its pixel is accepted, or at
    // once when it was off-screen (presented with pixel_valid low).
    assign slot_done_s = !pixel_valid_r || pix.pixel_ready;

    // Next-state, scanner control and origin selection.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        clear_s       = 1'b0;
        advance_s     = 1'b0;
        latch_s       = 1'b0;
        commit_s      = 1'b0;
        done_nxt_s    = 1'b0;
        origin_x_s    = new_x_r;
        origin_y_s    = new_y_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    pending_nxt_s = 1'b0;
                    latch_s       = 1'b1;
                    if (drawn_valid_r && (ball_x == old_x_r) && (ball_y == old_y_r)) begin
                        done_nxt_s = 1'b1;
                    end else if (drawn_valid_r) begin
                        state_nxt_s = ERASE;
                        clear_s     = 1'b1;
                        origin_x_s  = old_x_r;
                        origin_y_s  = old_y_r;
                    end else begin
                        // New coordinates are not latched yet: use the inputs.
                        state_nxt_s = DRAW;
                        clear_s     = 1'b1;
                        origin_x_s  = ball_x;
                        origin_y_s  = ball_y;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ERASE: begin
                pending_nxt_s = pending_r || frame_tick;
                origin_x_s    = old_x_r;
                origin_y_s    = old_y_r;
                if (slot_done_s) begin
                    if (last_s) begin
                        state_nxt_s = DRAW;
                        clear_s     = 1'b1;
                        origin_x_s  = new_x_r;
                        origin_y_s  = new_y_r;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    advance_s = 1'b0;
                end
            end
            DRAW: begin
                pending_nxt_s = pending_r || frame_tick;
                if (slot_done_s) begin
                    if (last_s) begin
                        state_nxt_s = IDLE;
                        commit_s    = 1'b1;
                        done_nxt_s  = 1'b1;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    advance_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control state, position history and registered pixel outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            pending_r      <= 1'b0;
            drawn_valid_r  <= 1'b0;
            old_x_r        <= 8'd0;
            old_y_r        <= 9'd0;
            new_x_r        <= 8'd0;
            new_y_r        <= 9'd0;
            pixel_valid_r  <= 1'b0;
            pixel_x_r      <= 8'd0;
            pixel_y_r      <= 9'd0;
            pixel_colour_r <= 16'd0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            if (latch_s) begin
                new_x_r <= ball_x;
                new_y_r <= ball_y;
            end
            if (commit_s) begin
                old_x_r       <= new_x_r;
                old_y_r       <= new_y_r;
                drawn_valid_r <= 1'b1;
            end
            // While stalled the scanner inputs are unchanged, so the
            // presented pixel is simply re-registered with the same value.
            pixel_valid_r <= (state_nxt_s != IDLE) && next_in_bounds_s;
            if (state_nxt_s != IDLE) begin
                pixel_x_r      <= next_x_s;
                pixel_y_r      <= next_y_s;
                pixel_colour_r <= (state_nxt_s == ERASE) ? BG_COLOUR : FG_COLOUR;
            end
        end
    end

    assign pix.pixel_valid  = pixel_valid_r;
    assign pix.pixel_x      = pixel_x_r;
    assign pix.pixel_y      = pixel_y_r;
    assign pix.pixel_colour = pixel_colour_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_ball_sprite_drawer.sv
// Self-checking bench for ball_sprite_drawer: a table of tick vectors with
// hand-derived expectations, then hand-written sequences for ticks while
// busy and reset in the middle of a draw.
module tb_ball_sprite_drawer;

    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] c;
    } pix_t;

    // kind: 0 = skipped update, 1 = draw only, 2 = erase old then draw
    typedef struct {
        int do_reset;
        int bx;
        int by;
        int mode;
        int kind;
        int ox;
        int oy;
        int exp_done;
        int exp_valid;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       frame_tick;
    logic [7:0] ball_x;
    logic [8:0] ball_y;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    pix_t acc_q[$];
    pix_t exp_q[$];
    vec_t vecs[5];

    ball_sprite_drawer_if pif ();

    ball_sprite_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .pix        (pif.master),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_square(input int ox, input int oy, input logic [15:0] col);
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                int x;
                int y;
                x = ox + c;
                y = oy + r;
                if (x < 240 && y < 320) exp_q.push_back('{8'(x), 9'(y), col});
            end
        end
    endtask

    task automatic compare_pixels(input string name);
        int mism;
        int n;
        mism = 0;
        check({name, "_count"}, acc_q.size(), exp_q.size());
        n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (acc_q[i] !== exp_q[i]) begin
                if (mism == 0)
                    $display("  %s first difference at %0d: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                             name, i, acc_q[i].x, acc_q[i].y, acc_q[i].c,
                             exp_q[i].x, exp_q[i].y, exp_q[i].c);
                mism++;
            end
        end
        check({name, "_order"}, mism, 0);
    endtask

    // Runs up to max_cyc cycles, recording accepted pixels; stops at done.
    task automatic collect(input int mode, input int max_cyc, input int busy_ticks,
                           output int done_cyc, output int valid_cyc, output int stab_err);
        pix_t prev;
        pix_t cur;
        logic prev_stall;
        acc_q.delete();
        done_cyc   = -1;
        valid_cyc  = 0;
        stab_err   = 0;
        prev_stall = 1'b0;
        prev       = '0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge clock);
            #1;
            frame_tick = (busy_ticks != 0) && (n == 5 || n == 7 || n == 9);
            if (busy_ticks != 0 && n == 5) begin
                ball_x = 8'd50;
                ball_y = 9'd40;
            end
            pif.pixel_ready = (mode == 0) ? 1'b1 : ((n % 4) == 1);
            @(negedge clock);
            cur = '{pif.pixel_x, pif.pixel_y, pif.pixel_colour};
            if (prev_stall && (!pif.pixel_valid || cur !== prev)) stab_err++;
            if (pif.pixel_valid) begin
                valid_cyc++;
                if (pif.pixel_ready) acc_q.push_back(cur);
            end
            prev_stall = pif.pixel_valid && !pif.pixel_ready;
            prev       = cur;
            if (done) begin
                done_cyc = n;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        frame_tick      = 1'b0;
        pif.pixel_ready = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_valid", int'(pif.pixel_valid), 0);
        check("rst_x", int'(pif.pixel_x), 0);
        check("rst_y", int'(pif.pixel_y), 0);
        check("rst_colour", int'(pif.pixel_colour), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
    endtask

    task automatic tick(input int bx, input int by);
        ball_x     = 8'(bx);
        ball_y     = 9'(by);
        frame_tick = 1'b1;
    endtask

    initial begin
        int dc;
        int vc;
        int se;
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        frame_tick      = 1'b0;
        ball_x          = 8'd0;
        ball_y          = 9'd0;
        pif.pixel_ready = 1'b1;

        vecs[0] = '{1, 120, 160, 0, 1, 0,   0,   101, 100};
        vecs[1] = '{0, 121, 161, 0, 2, 120, 160, 201, 200};
        vecs[2] = '{0, 121, 161, 0, 0, 0,   0,   1,   0};
        vecs[3] = '{0, 122, 162, 1, 2, 121, 161, -1,  -1};
        vecs[4] = '{1, 235, 315, 0, 1, 0,   0,   101, 25};

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].do_reset != 0) do_reset();
            exp_q.delete();
            if (vecs[v].kind == 2) add_square(vecs[v].ox, vecs[v].oy, 16'h0000);
            if (vecs[v].kind != 0) add_square(vecs[v].bx, vecs[v].by, 16'hFFFF);
            tick(vecs[v].bx, vecs[v].by);
            collect(vecs[v].mode, 2000, 0, dc, vc, se);
            compare_pixels($sformatf("vec%0d_pix", v));
            check($sformatf("vec%0d_stable", v), se, 0);
            if (vecs[v].exp_done >= 0) check($sformatf("vec%0d_done_cycle", v), dc, vecs[v].exp_done);
            else check($sformatf("vec%0d_done_seen", v), int'(dc > 0), 1);
            if (vecs[v].exp_valid >= 0) check($sformatf("vec%0d_valid_cycles", v), vc, vecs[v].exp_valid);
            check($sformatf("vec%0d_busy_after", v), int'(busy), 0);
        end

        // Three ticks while busy collapse into one follow-on update at (50,40).
        exp_q.delete();
        add_square(235, 315, 16'h0000);
        add_square(10, 20, 16'hFFFF);
        tick(10, 20);
        collect(0, 400, 1, dc, vc, se);
        compare_pixels("busy_first");
        check("busy_first_done", dc, 201);
        exp_q.delete();
        add_square(10, 20, 16'h0000);
        add_square(50, 40, 16'hFFFF);
        collect(0, 400, 0, dc, vc, se);
        compare_pixels("busy_follow");
        check("busy_follow_done", dc, 201);
        collect(0, 20, 0, dc, vc, se);
        check("busy_no_third_valid", vc, 0);
        check("busy_no_third_done", dc, -1);

        // Reset in the middle of DRAW aborts; the next update does not erase.
        tick(100, 100);
        collect(0, 150, 0, dc, vc, se);
        check("mid_accepts", acc_q.size(), 150);
        check("mid_no_done", dc, -1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort_valid", int'(pif.pixel_valid), 0);
        check("abort_busy", int'(busy), 0);
        collect(0, 10, 0, dc, vc, se);
        check("abort_quiet", vc, 0);
        exp_q.delete();
        add_square(60, 60, 16'hFFFF);
        tick(60, 60);
        collect(0, 400, 0, dc, vc, se);
        compare_pixels("after_abort");
        check("after_abort_done", dc, 101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
